gpu: RTL and testbench

Command-driven 2D line-drawing engine between the host command port and the SDRAM frame buffer. It accepts 32-bit command words through a write-only FIFO port and decodes colour, vertex and end-of-polyline commands. Each polyline segment is rasterised with Bresenham's algorithm, and one 32-bit pixel write per pixel is issued on an Avalon-MM-style master port into a 640x480 linear frame buffer.

---
 rtl/gpu.sv | 265 ++++++++++++++++++++++++++
 tb/tb_gpu.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu.sv
// gpu: command-driven Bresenham line engine.
// Host command words go into an 8-deep FIFO. The FSM pops BEGIN, VERTEX and
// END commands and rasterises each polyline segment into a 640x480 linear
// frame buffer, one registered Avalon-style pixel write per unclipped pixel.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | pop and decode one command word when the FIFO is non-empty
// SETUP | one cycle: deltas, step directions and initial error term
// DRAW  | present current pixel (or skip if clipped), then step
module gpu (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fifo_write_data,
    input  logic        fifo_write,
    input  logic        SD_waitrequest,
    output logic        SD_write,
    output logic [31:0] SD_wdata,
    output logic [21:0] SD_address
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2
    } state_t;

    localparam logic [3:0] OP_VERTEX = 4'h0;
    localparam logic [3:0] OP_BEGIN  = 4'h1;
    localparam logic [3:0] OP_END    = 4'h2;

    // Command FIFO storage and pointers
    logic [31:0] fifo_mem [8];
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  count_q, count_d;
    logic        push;
    logic        pop;
    logic [31:0] cmd_word;

    // Decoder / polyline state
    state_t      state_q, state_d;
    logic [23:0] colour_q, colour_d;
    logic        active_q, active_d;
    logic        have_prev_q, have_prev_d;
    logic [11:0] prev_x_q, prev_x_d;
    logic [15:0] prev_y_q, prev_y_d;

    // Raster state; x and y stay within the segment's bounding box
    logic [11:0] cx_q, cx_d;
    logic [15:0] cy_q, cy_d;
    logic [11:0] end_x_q, end_x_d;
    logic [15:0] end_y_q, end_y_d;
    logic signed [19:0] dx_q, dx_d;
    logic signed [19:0] dy_q, dy_d;
    logic signed [19:0] err_q, err_d;
    logic        sx_q, sx_d;
    logic        sy_q, sy_d;
    logic        last_q, last_d;

    // Registered master-port outputs
    logic        sd_write_q, sd_write_d;
    logic [21:0] sd_addr_q, sd_addr_d;
    logic [31:0] sd_wdata_q, sd_wdata_d;

    // Helpers for SETUP and DRAW
    logic signed [19:0] ddx, ddy, adx, ady, e2, err_n;
    logic [11:0] vx;
    logic [15:0] vy;
    logic        clip;
    logic        at_end;
    logic        advance;
    logic [21:0] addr_calc;

    assign cmd_word  = fifo_mem[rd_ptr_q];
    assign vx        = cmd_word[27:16];
    assign vy        = cmd_word[15:0];
    assign ddx       = $signed({8'b0, end_x_q}) - $signed({8'b0, cx_q});
    assign ddy       = $signed({4'b0, end_y_q}) - $signed({4'b0, cy_q});
    assign adx       = ddx[19] ? -ddx : ddx;
    assign ady       = ddy[19] ? -ddy : ddy;
    assign e2        = err_q <<< 1;
    assign clip      = (cx_q >= 12'd640) || (cy_q >= 16'd480);
    assign at_end    = (cx_q == end_x_q) && (cy_q == end_y_q);
    // A held write must stay frozen until the slave accepts it
    assign advance   = !(sd_write_q && SD_waitrequest);
    // Truncation to 22 bits is intended for out-of-range rows
    assign addr_calc = {6'b0, cy_q} * 22'd640 + {10'b0, cx_q};

    assign SD_write   = sd_write_q;
    assign SD_address = sd_addr_q;
    assign SD_wdata   = sd_wdata_q;

    // FIFO pointer and occupancy update; pushes while full are dropped
    always_comb begin
        push     = fifo_write && (count_q != 4'd8);
        wr_ptr_d = push ? wr_ptr_q + 3'd1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 3'd1 : rd_ptr_q;
        count_d  = count_q + {3'b0, push} - {3'b0, pop};
    end

    // FIFO storage write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= fifo_write_data;
        end
    end

    // Next-state, decode and Bresenham stepping
    always_comb begin
        state_d     = state_q;
        colour_d    = colour_q;
        active_d    = active_q;
        have_prev_d = have_prev_q;
        prev_x_d    = prev_x_q;
        prev_y_d    = prev_y_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        end_x_d     = end_x_q;
        end_y_d     = end_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        last_d      = last_q;
        sd_write_d  = sd_write_q;
        sd_addr_d   = sd_addr_q;
        sd_wdata_d  = sd_wdata_q;
        pop         = 1'b0;
        err_n       = err_q;

        case (state_q)
            ST_IDLE: begin
                sd_write_d = 1'b0;
                if (count_q != 4'd0) begin
                    pop = 1'b1;
                    case (cmd_word[31:28])
                        OP_BEGIN: begin
                            colour_d    = cmd_word[23:0];
                            active_d    = 1'b1;
                            have_prev_d = 1'b0;
                        end
                        OP_VERTEX: begin
                            if (active_q) begin
                                if (have_prev_q) begin
                                    cx_d    = prev_x_q;
                                    cy_d    = prev_y_q;
                                    end_x_d = vx;
                                    end_y_d = vy;
                                    state_d = ST_SETUP;
                                end
                                prev_x_d    = vx;
                                prev_y_d    = vy;
                                have_prev_d = 1'b1;
                            end
                        end
                        OP_END: begin
                            active_d = 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_SETUP: begin
                sd_write_d = 1'b0;
                dx_d       = adx;
                dy_d       = -ady;
                sx_d       = ddx[19];
                sy_d       = ddy[19];
                err_d      = adx - ady;
                last_d     = 1'b0;
                state_d    = ST_DRAW;
            end

            ST_DRAW: begin
                if (advance) begin
                    if (last_q) begin
                        // endpoint write has just completed (or was clipped)
                        sd_write_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        sd_write_d = !clip;
                        if (!clip) begin
                            sd_addr_d  = addr_calc;
                            sd_wdata_d = {8'h00, colour_q};
                        end
                        if (at_end) begin
                            last_d = 1'b1;
                        end else begin
                            if (e2 >= dy_q) begin
                                err_n = err_n + dy_q;
                                cx_d  = sx_q ? cx_q - 12'd1 : cx_q + 12'd1;
                            end
                            if (e2 <= dx_q) begin
                                err_n = err_n + dx_q;
                                cy_d  = sy_q ? cy_q - 16'd1 : cy_q + 16'd1;
                            end
                            err_d = err_n;
                        end
                    end
                end
            end

            default: begin
                sd_write_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any segment and empties the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            colour_q    <= '0;
            active_q    <= 1'b0;
            have_prev_q <= 1'b0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            last_q      <= 1'b0;
            sd_write_q  <= 1'b0;
            sd_addr_q   <= '0;
            sd_wdata_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            colour_q    <= colour_d;
            active_q    <= active_d;
            have_prev_q <= have_prev_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            end_x_q     <= end_x_d;
            end_y_q     <= end_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            last_q      <= last_d;
            sd_write_q  <= sd_write_d;
            sd_addr_q   <= sd_addr_d;
            sd_wdata_q  <= sd_wdata_d;
        end
    end

endmodule

// File: tb/tb_gpu.sv
// Testbench for gpu: directed and randomized polylines checked against a
// software line-drawing model of the command stream.
module tb_gpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fifo_write_data;
    logic        fifo_write;
    logic        SD_waitrequest;
    logic        SD_write;
    logic [31:0] SD_wdata;
    logic [21:0] SD_address;

    gpu dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_write_data (fifo_write_data),
        .fifo_write      (fifo_write),
        .SD_waitrequest  (SD_waitrequest),
        .SD_write        (SD_write),
        .SD_wdata        (SD_wdata),
        .SD_address      (SD_address)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [53:0] exp_q[$];
    logic [53:0] got_q[$];

    logic [23:0] m_colour;
    bit          m_active;
    bit          m_has_prev;
    int          m_px, m_py;
    bit          rand_stall = 1'b0;

    logic [53:0] hold_v;
    bit          hold_prev = 1'b0;

    function automatic void model_reset();
        m_colour   = '0;
        m_active   = 1'b0;
        m_has_prev = 1'b0;
        m_px       = 0;
        m_py       = 0;
    endfunction

    // Textbook integer Bresenham, pixels listed start to end
    function automatic void model_line(int x0, int y0, int x1, int y1);
        int dx, dy, sx, sy, err, e2, x, y;
        logic [21:0] a;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        while (1) begin
            if (x < 640 && y < 480) begin
                a = 22'(y * 640 + x);
                exp_q.push_back({a, 8'h00, m_colour});
            end
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    function automatic void model_cmd(logic [31:0] w);
        int vx, vy;
        case (w[31:28])
            4'h1: begin
                m_colour   = w[23:0];
                m_active   = 1'b1;
                m_has_prev = 1'b0;
            end
            4'h0: begin
                if (m_active) begin
                    vx = int'(w[27:16]);
                    vy = int'(w[15:0]);
                    if (m_has_prev) model_line(m_px, m_py, vx, vy);
                    m_px       = vx;
                    m_py       = vy;
                    m_has_prev = 1'b1;
                end
            end
            4'h2: m_active = 1'b0;
            default: ;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_stall) SD_waitrequest = ($urandom_range(0, 3) == 0);
    endtask

    task automatic push(input logic [31:0] w, input bit modeled);
        fifo_write      = 1'b1;
        fifo_write_data = w;
        tick();
        fifo_write      = 1'b0;
        if (modeled) model_cmd(w);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (30) tick();
    endtask

    task automatic compare_writes(input string tag);
        int bad = -1;
        int n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        end
        if (bad >= 0) $display("  %s pixel %0d got %h want %h", tag, bad, got_q[bad], exp_q[bad]);
        check({tag, "_first_bad_pixel"}, 64'(bad), 64'(-1));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_write_high(input int budget, output int n);
        n = 0;
        while (SD_write !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Collect accepted writes and check that stalled writes are held
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                assert ({SD_write, SD_address, SD_wdata} === {1'b1, hold_v})
                else begin
                    errors++;
                    $error("FAIL stall_hold observed=%h expected=%h",
                           {SD_write, SD_address, SD_wdata}, {1'b1, hold_v});
                end
            end
            if (SD_write === 1'b1 && SD_waitrequest === 1'b0)
                got_q.push_back({SD_address, SD_wdata});
            hold_prev = (SD_write === 1'b1) && (SD_waitrequest === 1'b1);
            hold_v    = {SD_address, SD_wdata};
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, run, gc;
        logic [53:0] hv;
        logic [31:0] w;

        reset           = 1'b0;
        fifo_write      = 1'b0;
        fifo_write_data = '0;
        SD_waitrequest  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_sd_write", 64'(SD_write), 64'd0);
        check("reset_sd_address", 64'(SD_address), 64'd0);
        check("reset_sd_wdata", 64'(SD_wdata), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Horizontal segment (30,100)->(130,100)
        push(32'h10000002, 1);
        push(32'h001E0064, 1);
        push(32'h00820064, 1);
        wait_write_high(20, lat);
        check("first_write_latency_ok", 64'(lat >= 3 && lat < 20), 64'd1);
        run = 0;
        while (SD_write === 1'b1 && run < 2000) begin
            run++;
            tick();
        end
        check("seg1_run_length", 64'(run), 64'd101);
        wait_drain(500);
        check("seg1_first_addr", (got_q.size() > 0) ? 64'(got_q[0][53:32]) : 64'hdead, 64'd64030);
        check("seg1_last_addr", (got_q.size() > 0) ? 64'(got_q[got_q.size()-1][53:32]) : 64'hdead, 64'd64130);
        check("seg1_data", (got_q.size() > 0) ? 64'(got_q[0][31:0]) : 64'hdead, 64'h2);
        compare_writes("seg1");

        // Diagonal (130,100)->(30,0) with a 5-cycle stall in the middle
        push(32'h001E0000, 1);
        wait_write_high(20, lat);
        repeat (10) tick();
        SD_waitrequest = 1'b1;
        hv = {SD_address, SD_wdata};
        gc = got_q.size();
        repeat (5) tick();
        check("stall_frozen", 64'({SD_write, SD_address, SD_wdata}), 64'({1'b1, hv}));
        check("stall_no_count", 64'(got_q.size()), 64'(gc));
        SD_waitrequest = 1'b0;
        wait_drain(500);
        check("seg2_last_addr", (got_q.size() > 0) ? 64'(got_q[got_q.size()-1][53:32]) : 64'hdead, 64'd30);
        compare_writes("seg2");

        // Three short segments then END
        push(32'h0014000A, 1);
        push(32'h001E000A, 1);
        push(32'h00140014, 1);
        push(32'h20000000, 1);
        wait_drain(500);
        check("seg3_total", 64'(got_q.size()), 64'd33);
        compare_writes("seg3");

        // Vertex after END, and single vertex polyline: nothing drawn
        push(32'h0005000A, 1);
        push(32'h10ABCDEF, 1);
        push(32'h00050005, 1);
        push(32'h20000000, 1);
        wait_drain(200);
        check("no_draw_count", 64'(got_q.size()), 64'd0);
        compare_writes("no_draw");

        // Random polylines with random stalls and clipping
        rand_stall = 1'b1;
        for (int p = 0; p < 4; p++) begin
            push({8'h10, 24'($urandom)}, 1);
            push({4'h0, 12'($urandom_range(0, 700)), 16'($urandom_range(0, 520))}, 1);
            push({4'h5, 28'($urandom)}, 1);
            push({4'h0, 12'($urandom_range(0, 700)), 16'($urandom_range(0, 520))}, 1);
            push({4'h0, 12'($urandom_range(0, 700)), 16'($urandom_range(0, 520))}, 1);
            push(32'h20000000, 1);
            push({4'h0, 12'($urandom_range(0, 700)), 16'($urandom_range(0, 520))}, 1);
            wait_drain(8000);
            compare_writes("random");
        end
        rand_stall     = 1'b0;
        SD_waitrequest = 1'b0;

        // Overflow: nine pushes while busy, the ninth is dropped
        push(32'h10123456, 1);
        push(32'h00000000, 1);
        push(32'h027F0000, 1);
        wait_write_high(20, lat);
        for (int i = 1; i <= 9; i++) begin
            w = {4'h0, 12'd600, 16'(i)};
            push(w, i <= 8);
        end
        check("busy_during_pushes", 64'(SD_write), 64'd1);
        wait_drain(3000);
        compare_writes("overflow");
        push(32'h20000000, 1);

        // Reset mid-segment
        push(32'h10FFFFFF, 1);
        push(32'h00000000, 1);
        push(32'h027F01DF, 1);
        push(32'h00000000, 1);
        wait_write_high(20, lat);
        repeat (20) tick();
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_write", 64'(SD_write), 64'd0);
        check("reset_async_addr", 64'(SD_address), 64'd0);
        got_q.delete();
        exp_q.delete();
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        repeat (50) tick();
        check("fifo_flushed", 64'(got_q.size()), 64'd0);
        push(32'h00100010, 1);
        push(32'h00200020, 1);
        repeat (20) tick();
        check("inactive_after_reset", 64'(got_q.size()), 64'd0);
        push(32'h10000077, 1);
        push(32'h00050005, 1);
        push(32'h00070006, 1);
        push(32'h20000000, 1);
        wait_drain(200);
        compare_writes("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
